// File: rtl/riot_multi_timer.sv
// rtl/riot_multi_timer.sv - RIOT-style ports, PA edge detector and 1-4 interval timers
// Scratch RAM is present only when RIOT_RAM_EN is defined.
module riot_multi_timer #(
    parameter int NUM_TIMERS = 2,
    parameter int TIMER_W    = 8,
    parameter int RAM_AW     = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [6:0] addr,
    input  logic       RW_n,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    input  logic       RS_n,
    input  logic       CS1,
    input  logic       CS2_n,
    output logic       IRQ_n,
    input  logic [7:0] PA_in,
    input  logic [7:0] PB_in,
    output logic [7:0] PA_out,
    output logic [7:0] PB_out,
    output logic       oe
);
    // Counters are kept 16 bits wide; the mask pins the upper byte to zero for 8-bit builds.
    localparam logic [15:0] CMASK = (TIMER_W == 16) ? 16'hFFFF : 16'h00FF;
    localparam logic [2:0]  NT    = 3'(NUM_TIMERS);

    logic [7:0]  ora, dda, orb, ddb;
    logic [15:0] cnt   [4];
    logic [15:0] latch [4];
    logic [9:0]  presc [4];
    logic [1:0]  psel  [4];
    logic [3:0]  irq_en, reload, roll, flags;
    logic        edge_flag, edge_pol, edge_irq_en, edge_prev;
    logic [2:0]  edge_idx;

`ifdef RIOT_RAM_EN
    logic [7:0]  ram [2**RAM_AW];
`endif

    logic        sel, wr, rd, tmr_sel, tsel_ok, edge_pin, edge_hit;
    logic [1:0]  tsel;
    logic [7:0]  rdata, pa_res;
    logic [15:0] commit_val;
    logic [3:0]  tick, zero, commit, lo_rd;
    logic        unused_bits;

    assign sel     = CS1 & ~CS2_n;
    assign oe      = sel & RW_n;
    assign wr      = sel & ce & ~RW_n;
    assign rd      = sel & ce & RW_n;
    assign tmr_sel = RS_n & addr[4];
    assign tsel    = addr[3:2];
    assign tsel_ok = {1'b0, tsel} < NT;

    assign PA_out = ora | ~dda;
    assign PB_out = orb | ~ddb;
    assign IRQ_n  = ~(|(flags & irq_en) | (edge_flag & edge_irq_en));

    // The edge detector watches the driven value on output pins, the pad on input pins.
    assign pa_res   = (dda & ora) | (~dda & PA_in);
    assign edge_pin = pa_res[edge_idx];
    assign edge_hit = edge_pol ? (edge_pin & ~edge_prev) : (~edge_pin & edge_prev);

    assign commit_val = (addr[1:0] == 2'd0) ? ({latch[tsel][15:8], d_in} & CMASK)
                                            : ({d_in, latch[tsel][7:0]} & CMASK);
    assign unused_bits = ^{addr[6:5], RAM_AW[0]};

    always_comb begin
        tick   = '0;
        zero   = '0;
        commit = '0;
        lo_rd  = '0;
        for (int i = 0; i < 4; i++) begin
            tick[i]   = roll[i] | (psel[i] == 2'd0)
                      | ((psel[i] == 2'd1) && (presc[i][2:0] == 3'd0))
                      | ((psel[i] == 2'd2) && (presc[i][5:0] == 6'd0))
                      | ((psel[i] == 2'd3) && (presc[i] == 10'd0));
            zero[i]   = (cnt[i] & CMASK) == 16'd0;
            commit[i] = wr & tmr_sel & tsel_ok & (tsel == 2'(i))
                      & ((addr[1:0] == 2'd1) | ((addr[1:0] == 2'd0) & (TIMER_W != 16)));
            lo_rd[i]  = rd & tmr_sel & (tsel == 2'(i)) & (addr[1:0] == 2'd0);
        end
    end

    always_comb begin
        rdata = 8'hFF;
        if (!RS_n) begin
`ifdef RIOT_RAM_EN
            rdata = ram[addr[RAM_AW-1:0]];
`endif
        end else if (!addr[4]) begin
            case (addr[1:0])
                2'd0:    rdata = PA_in & PA_out;
                2'd1:    rdata = dda;
                2'd2:    rdata = PB_in & PB_out;
                default: rdata = ddb;
            endcase
        end else if (addr[1:0] == 2'd3) begin
            rdata = {edge_flag, 3'b000, flags};
        end else if (tsel_ok) begin
            case (addr[1:0])
                2'd0:    rdata = cnt[tsel][7:0];
                2'd1:    rdata = cnt[tsel][15:8];
                default: rdata = {4'h0, reload[tsel], irq_en[tsel], psel[tsel]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out       <= 8'hFF;
            ora         <= '0;
            dda         <= '0;
            orb         <= '0;
            ddb         <= '0;
            irq_en      <= '0;
            reload      <= '0;
            roll        <= '0;
            flags       <= '0;
            edge_flag   <= 1'b0;
            edge_pol    <= 1'b0;
            edge_irq_en <= 1'b0;
            edge_prev   <= 1'b0;
            edge_idx    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i]   <= CMASK;
                latch[i] <= 16'hFFFF;
                presc[i] <= '0;
                psel[i]  <= 2'd2;
            end
`ifdef RIOT_RAM_EN
            for (int j = 0; j < 2**RAM_AW; j++) ram[j] <= '0;
`endif
        end else begin
            if (sel) d_out <= rdata;
            if (ce) begin
                edge_prev <= edge_pin;
                if (rd && tmr_sel && addr[1:0] == 2'd3) edge_flag <= 1'b0;
                if (edge_hit) edge_flag <= 1'b1;
                // Later assignments win: read-clear < zero-tick set < commit.
                for (int i = 0; i < 4; i++) begin
                    if (i < NUM_TIMERS) begin
                        presc[i] <= presc[i] + 10'd1;
                        if (lo_rd[i]) flags[i] <= 1'b0;
                        if (tick[i]) begin
                            if (zero[i]) begin
                                flags[i] <= 1'b1;
                                if (reload[i]) begin
                                    cnt[i] <= latch[i] & CMASK;
                                end else begin
                                    cnt[i]  <= CMASK;
                                    roll[i] <= 1'b1;
                                end
                            end else begin
                                cnt[i] <= (cnt[i] - 16'd1) & CMASK;
                            end
                        end
                        if (commit[i]) begin
                            cnt[i]   <= commit_val;
                            presc[i] <= '0;
                            flags[i] <= 1'b0;
                            roll[i]  <= 1'b0;
                        end
                    end
                end
                if (wr) begin
                    if (!RS_n) begin
`ifdef RIOT_RAM_EN
                        ram[addr[RAM_AW-1:0]] <= d_in;
`endif
                    end else if (!addr[4]) begin
                        case (addr[1:0])
                            2'd0:    ora <= d_in;
                            2'd1:    dda <= d_in;
                            2'd2:    orb <= d_in;
                            default: ddb <= d_in;
                        endcase
                    end else if (addr[1:0] == 2'd3) begin
                        edge_pol    <= d_in[0];
                        edge_irq_en <= d_in[1];
                        edge_idx    <= d_in[4:2];
                    end else if (tsel_ok) begin
                        case (addr[1:0])
                            2'd0: latch[tsel][7:0]  <= d_in;
                            2'd1: latch[tsel][15:8] <= d_in;
                            default: begin
                                psel[tsel]   <= d_in[1:0];
                                irq_en[tsel] <= d_in[2];
                                reload[tsel] <= d_in[3];
                            end
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: doc/riot_multi_timer.md
# riot_multi_timer

Parametrised successor of the 6532-style RIOT for the IEEE drive and CBM-II cores. It provides two 8-bit I/O ports with data-direction registers and a PA edge detector. It also has 1–4 independent interval timers, each 8 or 16 bits wide with its own prescaler and a one-shot or auto-reload mode, plus optional scratch RAM. It sits on the 6502 bus of the drive/peripheral CPU, exactly where the single-timer RIOT sits today.

## Interface
- NUM_TIMERS, 2, number of timer channels (1–4)
- TIMER_W, 8, counter width in bits (8 or 16)
- RAM_AW, 7, RAM address width (6 gives 64 B, 7 gives 128 B); ignored without RIOT_RAM_EN
- clk  in  1  system clock; one clock, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- ce  in  1  PHI2 clock enable
- addr  in  7  register/RAM address
- RW_n  in  1  1 = read, 0 = write
- d_in  in  8  write data
- d_out  out  8  registered read data
- RS_n  in  1  0 = RAM select
- CS1 / CS2_n  in  1/1  chip select; selected when CS1 & ~CS2_n
- IRQ_n  out  1  active-low interrupt
- PA_in, PB_in  in  8/8  port pins in
- PA_out, PB_out  out  8/8  out_x | ~dir_x (pull-up model)
- oe  out  1  selected & RW_n

## Operation
- Bus writes take effect on clk when ce=1. Reads update d_out on every clk while selected.
- RS_n=0 selects RAM at addr[RAM_AW-1:0]. A RAM write stores the byte. A RAM read returns it.
- RS_n=1 with addr[4]=0 selects the port registers via addr[1:0]:
  - 0 = ORA (read gives PA_in & PA_out)
  - 1 = DDRA
  - 2 = ORB (read gives PB_in & PB_out)
  - 3 = DDRB
- RS_n=1 with addr[4]=1 selects timer t=addr[3:2]. Accesses to t ≥ NUM_TIMERS write nothing and read 0xFF. addr[1:0] selects the register:
  - 0 = LO: a write latches the low byte; a read returns counter[7:0] and clears flag t.
  - 1 = HI: a write stores the high byte and commits. A read returns counter[15:8], or 0x00 when TIMER_W=8.
  - 2 = CTRL, read/write:
    - [1:0] prescale: 0 = ÷1, 1 = ÷8, 2 = ÷64, 3 = ÷1024
    - [2] irq_en
    - [3] reload mode
  - 3 = STATUS, shared by all t:
    - Read returns {edge_flag, 3'b0, timer_flags[3:0]} (unused timer bits read 0) and clears edge_flag.
    - Write sets [0] edge polarity (1 = rising), [1] edge irq_en, [4:2] PA pin index.
- Commit happens on the HI write, or on the LO write when TIMER_W=8. It sets counter to latch, prescaler to 0, flag t to 0 and rollover t to 0.
- Each timer has its own 10-bit prescaler, incremented every ce. A tick occurs when rollover is set, or when the selected low prescaler bits are all zero (÷1: every ce).
- On a tick with counter==0:
  - flag t is set;
  - one-shot mode: counter wraps to all ones, rollover is set, and it then decrements every ce;
  - reload mode: counter is set to latch and rollover stays 0.
- Edge detector: samples the selected PA pin (DDR-resolved) every ce and sets edge_flag on the programmed edge.
- IRQ_n = ~(|(flags & irq_en) | (edge_flag & edge_irq_en)).

## Timing
- Read latency is 1 clk: d_out is valid the cycle after the address is presented.
- Write side effects are visible on the next clk.
- Reset values:
  - d_out=0xFF, IRQ_n=1, oe follows its inputs
  - dir/out=0, so PA_out=PB_out=0xFF
  - counters all ones, latches all ones, prescale=2 (÷64)
  - reload=0, irq_en=0, all flags and edge config 0, RAM 0
- Simultaneous events:
  - Commit and zero-tick on the same ce: commit wins and the flag ends at 0.
  - LO read-clear and flag set on the same ce: set wins.
  - STATUS read and edge on the same ce: edge_flag ends at 1.
- A CTRL prescale write does not reset the prescaler. The new divide takes effect at the next aligned boundary.
- Reset asserted mid-count aborts all channels immediately. Reset dominates ce.

## Configuration
- RIOT_RAM_EN: when defined, RAM of 2^RAM_AW bytes is instantiated and RS_n is decoded.
- When undefined, there is no RAM storage: RS_n=0 reads return 0xFF and writes are ignored.

## Test plan
- Reset, then read DDRA/ORA with PA_in=0xFF → 0x00, 0xFF. Write DDRA=0x0F, ORA=0x05, PA_in=0xFF → PA_out=0xF5, read ORA=0xF5.
- Timer0 TIMER_W=8: CTRL=0x04 (÷1, irq), LO=3 → ticks read 3,2,1,0. IRQ_n falls on the ce when 0 is decremented, counter reads 0xFF then 0xFE. LO read → IRQ_n=1.
- TIMER_W=16 timer1: CTRL=0x0D (÷8, irq, reload), LO=0x01, HI=0x00 → flag every 16 ce. Counter reloads 0x0001 and never rolls over.
- Commit on the exact ce the counter hits 0 → flag stays 0, counter = new latch.
- STATUS write 0x1F (pin 7, rising, irq): PA7 0→1 → edge_flag=1, IRQ_n=0. STATUS read returns 0x80, then IRQ_n=1. Falling edge → no flag.
- With RIOT_RAM_EN: write RAM[0x7F]=0xA5, read → 0xA5. Without it → 0xFF.
